// File: rtl/cr_axi4s_frm_pop.sv
// cr_axi4s_frm_pop
//   Pops beats from a show-ahead FIFO and forwards them to an AXI4-Stream
//   style output through a single output register. Frames longer than
//   MAX_BEATS are truncated: the last forwarded beat gets out_last forced
//   high and the rest of the frame is drained from the FIFO and discarded.
//   A one-cycle statistics pulse reports forwarded beats, forwarded bytes
//   and a truncation flag for every frame.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   fifo_empty          : FIFO empty flag; fifo_rdata_* valid when 0
//   fifo_rdata_data/strb/last : head-of-FIFO beat
//   fifo_rd             : pop strobe, one beat per high cycle
//   out_valid/ready     : output handshake
//   out_data/strb/last  : output beat
//   stat_valid          : one-cycle frame statistics pulse
//   stat_beats          : beats forwarded in the frame
//   stat_bytes          : popcount of strobes over forwarded beats
//   stat_err            : frame exceeded MAX_BEATS and was truncated
module cr_axi4s_frm_pop #(
  parameter int MAX_BEATS  = 512,
  parameter int N_CNT_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic [63:0]             fifo_rdata_data,
  input  logic [7:0]              fifo_rdata_strb,
  input  logic                    fifo_rdata_last,
  output logic                    fifo_rd,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_data,
  output logic [7:0]              out_strb,
  output logic                    out_last,
  output logic                    stat_valid,
  output logic [N_CNT_BITS-1:0]   stat_beats,
  output logic [N_CNT_BITS+2:0]   stat_bytes,
  output logic                    stat_err
);

  localparam int BW = N_CNT_BITS + 3;
  localparam logic [N_CNT_BITS-1:0] MAX_CNT = N_CNT_BITS'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

  state_t                 state;
  logic [N_CNT_BITS-1:0]  beat_cnt;
  logic [BW-1:0]          byte_cnt;

  logic [N_CNT_BITS-1:0]  beat_num_p0;
  logic [BW-1:0]          bytes_sum_p0;
  logic                   at_max_p0;

  // Number of set strobe bits; strobes may be sparse.
  function automatic logic [3:0] popcnt8(input logic [7:0] s);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, s[i]};
    end
    return c;
  endfunction

  // Stage p0: head-of-FIFO beat, pop decision and running frame totals.
  // In IDLE the popped beat is the first of a new frame, so the
  // accumulators restart from zero rather than from their held values.
  always_comb begin
    beat_num_p0  = (state == IDLE) ? N_CNT_BITS'(1) : beat_cnt + N_CNT_BITS'(1);
    bytes_sum_p0 = ((state == IDLE) ? '0 : byte_cnt) + BW'(popcnt8(fifo_rdata_strb));
    at_max_p0    = (beat_num_p0 == MAX_CNT);
    if (rst || fifo_empty) begin
      fifo_rd = 1'b0;
    end else if (state == DROP) begin
      // Discarded beats never touch the output register, so draining
      // does not wait for the downstream.
      fifo_rd = 1'b1;
    end else begin
      fifo_rd = ~out_valid | out_ready;
    end
  end

  // Stage p1: output register, statistics and frame state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      byte_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_strb   <= '0;
      out_last   <= 1'b0;
      stat_valid <= 1'b0;
      stat_beats <= '0;
      stat_bytes <= '0;
      stat_err   <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (fifo_rd) begin
        if (state == DROP) begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (fifo_rdata_last) begin
            stat_valid <= 1'b1;
            stat_beats <= beat_cnt;
            stat_bytes <= byte_cnt;
            stat_err   <= 1'b1;
            beat_cnt   <= '0;
            byte_cnt   <= '0;
            state      <= IDLE;
          end
        end else begin
          out_valid <= 1'b1;
          out_data  <= fifo_rdata_data;
          out_strb  <= fifo_rdata_strb;
          // Truncated frames still present a terminated frame downstream.
          out_last  <= fifo_rdata_last | at_max_p0;
          if (fifo_rdata_last) begin
            stat_valid <= 1'b1;
            stat_beats <= beat_num_p0;
            stat_bytes <= bytes_sum_p0;
            stat_err   <= 1'b0;
            beat_cnt   <= '0;
            byte_cnt   <= '0;
            state      <= IDLE;
          end else begin
            beat_cnt <= beat_num_p0;
            byte_cnt <= bytes_sum_p0;
            state    <= at_max_p0 ? DROP : FRAME;
          end
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cr_axi4s_frm_pop.sv
module tb_cr_axi4s_frm_pop;

  localparam int MAXB = 4;
  localparam int NCB  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fifo_empty = 1'b1;
  logic [63:0]      fifo_rdata_data = '0;
  logic [7:0]       fifo_rdata_strb = '0;
  logic             fifo_rdata_last = 1'b0;
  logic             fifo_rd;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_data;
  logic [7:0]       out_strb;
  logic             out_last;
  logic             stat_valid;
  logic [NCB-1:0]   stat_beats;
  logic [NCB+2:0]   stat_bytes;
  logic             stat_err;

  cr_axi4s_frm_pop #(.MAX_BEATS(MAXB), .N_CNT_BITS(NCB)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_rdata_data(fifo_rdata_data),
    .fifo_rdata_strb(fifo_rdata_strb), .fifo_rdata_last(fifo_rdata_last),
    .fifo_rd(fifo_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_strb(out_strb), .out_last(out_last),
    .stat_valid(stat_valid), .stat_beats(stat_beats), .stat_bytes(stat_bytes),
    .stat_err(stat_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
    logic        l;
  } beat_t;

  beat_t fq[$];

  int tests = 0;
  int fails = 0;

  // Reference model: frame position and expected registered outputs.
  int          pop_idx = 0;
  int          acc_b = 0;
  int          acc_by = 0;
  logic        exp_ov = 1'b0;
  logic [63:0] exp_od = '0;
  logic [7:0]  exp_os = '0;
  logic        exp_ol = 1'b0;
  logic        exp_sv = 1'b0;
  int          exp_sb = 0;
  int          exp_sby = 0;
  logic        exp_se = 1'b0;

  // Observations used for the literal checks.
  int          hs_cnt = 0;
  int          stat_pulses = 0;
  int          pops_rdy_low = 0;
  int          cap_sb = 0;
  int          cap_sby = 0;
  int          cap_se = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [7:0] s, input logic l);
    beat_t b;
    b.d = {$urandom, $urandom};
    b.s = s;
    b.l = l;
    fq.push_back(b);
  endtask

  task automatic clr_cap();
    hs_cnt = 0;
    stat_pulses = 0;
    pops_rdy_low = 0;
  endtask

  // One clock cycle: drive inputs on the falling edge, check every output
  // against the model, then advance the model by what the coming rising
  // edge will do.
  task automatic cycle(input bit rdy, input bit stall, input bit r);
    beat_t b;
    bit    pop;
    bit    fwd;
    bit    exp_rd;
    int    n;
    @(negedge clk);
    rst = r;
    out_ready = rdy;
    if (r) fq.delete();
    if (fq.size() > 0 && !stall) begin
      fifo_empty      = 1'b0;
      fifo_rdata_data = fq[0].d;
      fifo_rdata_strb = fq[0].s;
      fifo_rdata_last = fq[0].l;
    end else begin
      fifo_empty      = 1'b1;
      fifo_rdata_data = {$urandom, $urandom};
      fifo_rdata_strb = 8'($urandom);
      fifo_rdata_last = 1'($urandom);
    end
    #1;
    exp_rd = !r && !fifo_empty && (pop_idx >= MAXB || !exp_ov || rdy);
    chk("fifo_rd",    64'(fifo_rd),    64'(exp_rd));
    chk("out_valid",  64'(out_valid),  64'(exp_ov));
    chk("out_data",   out_data,        exp_od);
    chk("out_strb",   64'(out_strb),   64'(exp_os));
    chk("out_last",   64'(out_last),   64'(exp_ol));
    chk("stat_valid", 64'(stat_valid), 64'(exp_sv));
    chk("stat_beats", 64'(stat_beats), 64'(exp_sb));
    chk("stat_bytes", 64'(stat_bytes), 64'(exp_sby));
    chk("stat_err",   64'(stat_err),   64'(exp_se));
    if (stat_valid === 1'b1) begin
      stat_pulses++;
      cap_sb  = int'(stat_beats);
      cap_sby = int'(stat_bytes);
      cap_se  = int'(stat_err);
    end
    if (out_valid === 1'b1 && rdy) hs_cnt++;
    if (fifo_rd === 1'b1 && !rdy) pops_rdy_low++;
    pop = (fifo_rd === 1'b1) && !fifo_empty && !r && (fq.size() > 0);

    if (r) begin
      pop_idx = 0; acc_b = 0; acc_by = 0;
      exp_ov = 0; exp_od = '0; exp_os = '0; exp_ol = 0;
      exp_sv = 0; exp_sb = 0; exp_sby = 0; exp_se = 0;
    end else begin
      exp_sv = 0;
      fwd = 0;
      n = 0;
      b.d = '0; b.s = '0; b.l = 1'b0;
      if (pop) begin
        b = fq.pop_front();
        pop_idx++;
        n = pop_idx;
        if (n <= MAXB) begin
          fwd = 1;
          acc_b++;
          acc_by += $countones(b.s);
        end
        if (b.l) begin
          exp_sv  = 1;
          exp_sb  = acc_b;
          exp_sby = acc_by;
          exp_se  = (n > MAXB);
          pop_idx = 0; acc_b = 0; acc_by = 0;
        end
      end
      if (fwd) begin
        exp_ov = 1;
        exp_od = b.d;
        exp_os = b.s;
        exp_ol = b.l || (n == MAXB);
      end else if (rdy) begin
        exp_ov = 0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((fq.size() > 0 || exp_ov) && k < budget) begin
      cycle(1'b1, 1'b0, 1'b0);
      k++;
    end
    chk("drain_left", 64'(fq.size()), 64'd0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset: all outputs must be zero while rst is held.
    repeat (3) cycle(1'b0, 1'b1, 1'b1);

    // 3-beat frame FF,FF,0F at full throughput.
    clr_cap();
    push_beat(8'hFF, 1'b0); push_beat(8'hFF, 1'b0); push_beat(8'h0F, 1'b1);
    drain(50);
    chk("t3_hs", 64'(hs_cnt), 64'd3);
    chk("t3_pulses", 64'(stat_pulses), 64'd1);
    chk("t3_beats", 64'(cap_sb), 64'd3);
    chk("t3_bytes", 64'(cap_sby), 64'd20);
    chk("t3_err", 64'(cap_se), 64'd0);

    // Single-beat frame, strb 01.
    clr_cap();
    push_beat(8'h01, 1'b1);
    drain(50);
    chk("t1_hs", 64'(hs_cnt), 64'd1);
    chk("t1_beats", 64'(cap_sb), 64'd1);
    chk("t1_bytes", 64'(cap_sby), 64'd1);
    chk("t1_err", 64'(cap_se), 64'd0);

    // 7-beat frame truncated to 4, then a normal 2-beat frame.
    clr_cap();
    for (int i = 0; i < 7; i++) push_beat(8'hFF, i == 6);
    drain(50);
    chk("tr_hs", 64'(hs_cnt), 64'd4);
    chk("tr_beats", 64'(cap_sb), 64'd4);
    chk("tr_bytes", 64'(cap_sby), 64'd32);
    chk("tr_err", 64'(cap_se), 64'd1);
    clr_cap();
    push_beat(8'hFF, 1'b0); push_beat(8'h03, 1'b1);
    drain(50);
    chk("tr_next_hs", 64'(hs_cnt), 64'd2);
    chk("tr_next_beats", 64'(cap_sb), 64'd2);
    chk("tr_next_bytes", 64'(cap_sby), 64'd10);
    chk("tr_next_err", 64'(cap_se), 64'd0);

    // Backpressure for 5 cycles mid-frame.
    clr_cap();
    for (int i = 0; i < 4; i++) push_beat(8'hFF, i == 3);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0);
    chk("bp_pops_low", 64'(pops_rdy_low), 64'd0);
    drain(50);
    chk("bp_hs", 64'(hs_cnt), 64'd4);
    chk("bp_beats", 64'(cap_sb), 64'd4);
    chk("bp_err", 64'(cap_se), 64'd0);

    // Truncation with out_ready low during the drop phase.
    clr_cap();
    for (int i = 0; i < 7; i++) push_beat(8'hFF, i == 6);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);
    chk("dr_pops_low", 64'(pops_rdy_low), 64'd3);
    chk("dr_pulses", 64'(stat_pulses), 64'd1);
    chk("dr_err", 64'(cap_se), 64'd1);
    drain(50);
    chk("dr_hs", 64'(hs_cnt), 64'd4);
    chk("dr_bytes", 64'(cap_sby), 64'd32);

    // Reset after beat 2 of a 5-beat frame.
    clr_cap();
    for (int i = 0; i < 5; i++) push_beat(8'hFF, i == 4);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    chk("rs_pulses", 64'(stat_pulses), 64'd0);
    push_beat(8'hFF, 1'b0); push_beat(8'hFF, 1'b1);
    drain(50);
    chk("rs_next_pulses", 64'(stat_pulses), 64'd1);
    chk("rs_next_beats", 64'(cap_sb), 64'd2);
    chk("rs_next_bytes", 64'(cap_sby), 64'd16);

    // Randomized frames, backpressure and FIFO bubbles.
    clr_cap();
    for (int f = 0; f < 50; f++) begin
      int len;
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++) push_beat(8'($urandom), i == len - 1);
    end
    begin
      int k;
      k = 0;
      while ((fq.size() > 0 || exp_ov) && k < 5000) begin
        cycle(($urandom % 4) != 0, ($urandom % 5) == 0, 1'b0);
        k++;
      end
    end
    drain(100);
    chk("rnd_pulses", 64'(stat_pulses), 64'd50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cr_axi4s_frm_pop.md
CR_AXI4S_FRM_POP -- requirements
Module: cr_axi4s_frm_pop

Interface
REQ-001 Parameter MAX_BEATS, default 512, maximum beats forwarded per frame; legal range 2..65535.
REQ-002 Parameter N_CNT_BITS, default 16, width of the beat counter; 2^N_CNT_BITS SHALL exceed MAX_BEATS.
REQ-003 Port clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port fifo_empty  input  1  FIFO empty flag; fifo_rdata_* are valid whenever it is 0 (show-ahead FIFO).
REQ-006 Port fifo_rdata_data  input  64  head-of-FIFO beat data.
REQ-007 Port fifo_rdata_strb  input  8  head-of-FIFO byte strobes.
REQ-008 Port fifo_rdata_last  input  1  head-of-FIFO end-of-frame marker.
REQ-009 Port fifo_rd  output  1  pop strobe; one beat consumed per cycle it is high.
REQ-010 Port out_valid  output  1  output beat valid.
REQ-011 Port out_ready  input  1  downstream accept.
REQ-012 Port out_data  output  64  output beat data.
REQ-013 Port out_strb  output  8  output byte strobes.
REQ-014 Port out_last  output  1  output end-of-frame marker.
REQ-015 Port stat_valid  output  1  one-cycle frame-statistics pulse.
REQ-016 Port stat_beats  output  N_CNT_BITS  beats forwarded in the frame.
REQ-017 Port stat_bytes  output  N_CNT_BITS+3  sum of popcount(strb) over forwarded beats.
REQ-018 Port stat_err  output  1  frame exceeded MAX_BEATS and was truncated.

Function
REQ-019 The block SHALL contain a single output register stage; a beat popped in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1.
REQ-020 The output register SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-021 The block SHALL drive fifo_rd = ~fifo_empty & (~out_valid | out_ready) in states IDLE and FRAME, giving full throughput (one beat per cycle) when out_ready is held high.
REQ-022 The block SHALL drive fifo_rd = ~fifo_empty in state DROP, independent of out_ready.
REQ-023 The block SHALL clear out_valid in the cycle after an out_ready handshake with no concurrent pop.
REQ-024 The FSM SHALL have states IDLE, FRAME and DROP; reset state IDLE.
REQ-025 IDLE: pop with last=1 -> emit stat, remain IDLE; pop with last=0 -> FRAME.
REQ-026 FRAME: pop with last=1 and beat count <= MAX_BEATS -> emit stat with stat_err=0, go to IDLE.
REQ-027 FRAME/IDLE: pop of beat number MAX_BEATS with last=0 -> forward that beat with out_last forced to 1, go to DROP.
REQ-028 DROP: popped beats SHALL be discarded (not written to the output register); pop with last=1 -> emit stat with stat_err=1, go to IDLE.
REQ-029 Beat and byte accumulators SHALL count forwarded beats only; they SHALL restart at the first beat of each frame.
REQ-030 stat_valid SHALL pulse for exactly one cycle, in the cycle after the pop of the frame-terminating FIFO beat; stat_* SHALL hold their values until the next pulse.
REQ-031 stat_bytes SHALL be the unsigned sum of popcount(fifo_rdata_strb); strobes are not required to be contiguous.
REQ-032 When fifo_empty=1, fifo_rd SHALL be 0 and no state, counter or output register SHALL change except out_valid clearing per REQ-023.

Reset
REQ-033 While rst=1, state SHALL be IDLE, counters 0, and fifo_rd, out_valid, out_last, stat_valid, stat_err, out_data, out_strb, stat_beats and stat_bytes SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no stat pulse; the first beat after reset release starts a new frame.

Verification
REQ-035 3-beat frame, strb FF,FF,0F, out_ready=1 -> 3 output beats on consecutive cycles, out_last on third, stat_beats=3, stat_bytes=20, stat_err=0.
REQ-036 Single-beat frame, last=1, strb 01 -> IDLE->IDLE, stat_beats=1, stat_bytes=1.
REQ-037 MAX_BEATS=4, 7-beat frame, all strb FF -> 4 beats forwarded, fourth with out_last=1; 3 beats popped and dropped; stat_beats=4, stat_bytes=32, stat_err=1; next frame forwarded normally.
REQ-038 out_ready low for 5 cycles mid-frame -> out_* held stable, fifo_rd=0 throughout, no beat lost or duplicated after release.
REQ-039 Same as REQ-037 with out_ready=0 during DROP -> dropped beats still drain at one per cycle; forwarded beat held on out_*.
REQ-040 rst pulsed after beat 2 of 5 -> no stat pulse; all outputs 0 during reset; next 2-beat frame reports stat_beats=2.
